// File: rtl/repne_cmps_sequencer.sv
// REPNE CMPS micro-op sequencer: expands a decoded CMPS into FIRST/SECOND micro-ops
// and, under REPNE, repeats the pair until writeback signals termination.
module repne_cmps_sequencer (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        D_V,
  input  logic        D_IS_CMPS,
  input  logic        D_REPNE,
  output logic        d_ready,
  output logic        UOP_V,
  input  logic        UOP_READY,
  output logic        CS_IS_CMPS_FIRST_UOP_ALL,
  output logic        CS_IS_CMPS_SECOND_UOP_ALL,
  output logic        d2_repne,
  input  logic        WB_CMPS_SECOND_DONE,
  input  logic        wb_repne_terminate_all,
  input  logic        wb_flush,
  output logic [15:0] iter_count,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_SECOND, S_WAIT_WB} state_t;

  state_t      state_q, state_d;
  logic        repne_q, repne_d;
  logic [15:0] iter_d;
  logic        pass;
  logic        uop_v_d, first_d, second_d, d2_d;

  assign d_ready = (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    repne_d = repne_q;
    iter_d  = iter_count;
    pass    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (D_V) begin
          if (D_IS_CMPS) begin
            state_d = S_FIRST;
            repne_d = D_REPNE;
            iter_d  = 16'h0000;
          end else begin
            pass = 1'b1;
          end
        end
      end
      S_FIRST:  if (UOP_READY) state_d = S_SECOND;
      S_SECOND: if (UOP_READY) state_d = repne_q ? S_WAIT_WB : S_IDLE;
      S_WAIT_WB: begin
        if (WB_CMPS_SECOND_DONE) begin
          if (iter_count != 16'hFFFF) iter_d = iter_count + 16'd1;
          state_d = wb_repne_terminate_all ? S_IDLE : S_FIRST;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush wins over everything, including an accept in IDLE and a retiring done.
    if (wb_flush) begin
      state_d = S_IDLE;
      repne_d = repne_q;
      iter_d  = iter_count;
      pass    = 1'b0;
    end
  end

  // Outputs are precomputed from the next state so they leave straight from flops.
  always_comb begin
    first_d  = (state_d == S_FIRST);
    second_d = (state_d == S_SECOND);
    uop_v_d  = pass | first_d | second_d;
    d2_d     = (first_d | second_d) & repne_d;
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q                   <= S_IDLE;
      repne_q                   <= 1'b0;
      iter_count                <= 16'h0000;
      UOP_V                     <= 1'b0;
      CS_IS_CMPS_FIRST_UOP_ALL  <= 1'b0;
      CS_IS_CMPS_SECOND_UOP_ALL <= 1'b0;
      d2_repne                  <= 1'b0;
      busy                      <= 1'b0;
    end else begin
      state_q                   <= state_d;
      repne_q                   <= repne_d;
      iter_count                <= iter_d;
      UOP_V                     <= uop_v_d;
      CS_IS_CMPS_FIRST_UOP_ALL  <= first_d;
      CS_IS_CMPS_SECOND_UOP_ALL <= second_d;
      d2_repne                  <= d2_d;
      busy                      <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_repne_cmps_sequencer.sv
// Directed bench for repne_cmps_sequencer; inputs change #1 after a rising edge
// and outputs are checked there too.
module tb_repne_cmps_sequencer;

  logic        CLK = 1'b0;
  logic        CLR, D_V, D_IS_CMPS, D_REPNE, UOP_READY;
  logic        WB_CMPS_SECOND_DONE, wb_repne_terminate_all, wb_flush;
  logic        d_ready, UOP_V, CS_IS_CMPS_FIRST_UOP_ALL, CS_IS_CMPS_SECOND_UOP_ALL;
  logic        d2_repne, busy;
  logic [15:0] iter_count;

  int n_chk = 0;
  int n_err = 0;

  always #1 CLK = ~CLK;

  repne_cmps_sequencer dut (
    .CLK(CLK), .CLR(CLR), .D_V(D_V), .D_IS_CMPS(D_IS_CMPS), .D_REPNE(D_REPNE),
    .d_ready(d_ready), .UOP_V(UOP_V), .UOP_READY(UOP_READY),
    .CS_IS_CMPS_FIRST_UOP_ALL(CS_IS_CMPS_FIRST_UOP_ALL),
    .CS_IS_CMPS_SECOND_UOP_ALL(CS_IS_CMPS_SECOND_UOP_ALL),
    .d2_repne(d2_repne), .WB_CMPS_SECOND_DONE(WB_CMPS_SECOND_DONE),
    .wb_repne_terminate_all(wb_repne_terminate_all), .wb_flush(wb_flush),
    .iter_count(iter_count), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Packed view of the beat outputs: {UOP_V, FIRST, SECOND, d2_repne, busy, d_ready}
  function automatic logic [5:0] beat();
    return {UOP_V, CS_IS_CMPS_FIRST_UOP_ALL, CS_IS_CMPS_SECOND_UOP_ALL, d2_repne, busy, d_ready};
  endfunction

  task automatic accept(input logic repne);
    D_V = 1'b1; D_IS_CMPS = 1'b1; D_REPNE = repne;
    step();
    D_V = 1'b0; D_IS_CMPS = 1'b0; D_REPNE = 1'b0;
  endtask

  task automatic done_pulse(input logic term);
    WB_CMPS_SECOND_DONE = 1'b1; wb_repne_terminate_all = term;
    step();
    WB_CMPS_SECOND_DONE = 1'b0; wb_repne_terminate_all = 1'b0;
  endtask

  initial begin
    CLR = 1'b0; D_V = 1'b0; D_IS_CMPS = 1'b0; D_REPNE = 1'b0; UOP_READY = 1'b1;
    WB_CMPS_SECOND_DONE = 1'b0; wb_repne_terminate_all = 1'b0; wb_flush = 1'b0;
    step(); step();
    chk("reset_beat", beat(), 6'b000001);
    chk("reset_iter", iter_count, 16'h0000);
    CLR = 1'b1;

    // non-CMPS pass-through: one beat, no flags, stays IDLE
    D_V = 1'b1; D_IS_CMPS = 1'b0;
    step();
    D_V = 1'b0;
    chk("pass_beat", beat(), 6'b100001);
    step();
    chk("pass_after", beat(), 6'b000001);

    // plain CMPS
    accept(1'b0);
    chk("plain_first", beat(), 6'b110010);
    step();
    chk("plain_second", beat(), 6'b101010);
    step();
    chk("plain_idle", beat(), 6'b000001);
    chk("plain_iter", iter_count, 16'h0000);

    // REPNE, terminate on the third done
    accept(1'b1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rep_first%0d", i), beat(), 6'b110110);
      step();
      chk($sformatf("rep_second%0d", i), beat(), 6'b101110);
      step();
      chk($sformatf("rep_wait%0d", i), beat(), 6'b000010);
      step();
      chk($sformatf("rep_wait_hold%0d", i), beat(), 6'b000010);
      chk($sformatf("rep_iter_pre%0d", i), iter_count, i);
      done_pulse(i == 2);
      chk($sformatf("rep_iter_post%0d", i), iter_count, i + 1);
    end
    chk("rep_end_beat", beat(), 6'b000001);
    chk("rep_end_iter", iter_count, 16'd3);

    // stall in FIRST for 4 cycles; a stray done there must be ignored
    UOP_READY = 1'b0;
    accept(1'b0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stall_first%0d", k), beat(), 6'b110010);
      if (k == 1) done_pulse(1'b1); else step();
    end
    chk("stall_held", beat(), 6'b110010);
    chk("stall_iter", iter_count, 16'h0000);
    UOP_READY = 1'b1;
    step();
    chk("stall_second", beat(), 6'b101010);
    step();
    chk("stall_idle", beat(), 6'b000001);

    // flush collides with a continue done in WAIT_WB
    accept(1'b1);
    step(); step();
    done_pulse(1'b0);
    chk("flush_iter1", iter_count, 16'd1);
    chk("flush_first", beat(), 6'b110110);
    step(); step();
    chk("flush_wait", beat(), 6'b000010);
    wb_flush = 1'b1;
    done_pulse(1'b0);
    wb_flush = 1'b0;
    chk("flush_beat", beat(), 6'b000001);
    chk("flush_iter", iter_count, 16'd1);
    step();
    chk("flush_no_first", beat(), 6'b000001);

    // saturation: 65536 continue pulses then terminate
    accept(1'b1);
    for (int n = 1; n <= 65536; n++) begin
      step(); step();
      done_pulse(1'b0);
      if (n == 65534) chk("sat_fffe", iter_count, 16'hFFFE);
      if (n == 65535) chk("sat_ffff", iter_count, 16'hFFFF);
    end
    chk("sat_65536", iter_count, 16'hFFFF);
    step(); step();
    done_pulse(1'b1);
    chk("sat_term_iter", iter_count, 16'hFFFF);
    chk("sat_term_beat", beat(), 6'b000001);

    // reset while a SECOND beat is stalled
    accept(1'b1);
    step(); step();
    done_pulse(1'b0);
    step();
    chk("rst_second", beat(), 6'b101110);
    UOP_READY = 1'b0; CLR = 1'b0;
    step();
    chk("rst_beat", beat(), 6'b000001);
    chk("rst_iter", iter_count, 16'h0000);
    CLR = 1'b1; UOP_READY = 1'b1;
    step();
    chk("rst_no_reissue", beat(), 6'b000001);
    step();
    chk("rst_still_idle", beat(), 6'b000001);

    // accept on the very first cycle after reset release
    CLR = 1'b0;
    step();
    CLR = 1'b1;
    chk("rel_ready", d_ready, 1'b1);
    accept(1'b0);
    chk("rel_first", beat(), 6'b110010);
    step(); step();
    chk("rel_idle", beat(), 6'b000001);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
